// File: rtl/lbm_pkg.sv
// Shared LBM types: one 8-bit density per lattice direction, nine directions per cell,
// plus the state encoding used by the collision sequencer.
package lbm_pkg;

    localparam int Q = 9;

    typedef logic [7:0] density_t;
    typedef density_t [8:0] cell_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        COLLIDE = 3'd2,
        WRITE   = 3'd3,
        FINISH  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/collision_sequencer.sv
// Collision sequencer: walks every lattice cell in address order, reads its density word from
// BRAM, hands it to the collision engine, waits for the engine's done pulse (or a timeout) and
// writes the result back to the same address. Cells are processed strictly one at a time, so a
// write always completes before the next read is issued.
module collision_sequencer
    import lbm_pkg::*;
#(
    parameter int GRID_W  = 64,
    parameter int GRID_H  = 48,
    parameter int ADDR_W  = 12,
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 63
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    input  cell_t             bram_rd_data_in,
    output logic              bram_we_out,
    output cell_t             bram_wr_data_out,
    output cell_t             coll_data_out,
    output logic              coll_valid_out,
    input  cell_t             coll_data_in,
    input  logic              coll_done_in
);

    // Last cell address of the lattice and the wait-counter limits, sized to their registers.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GRID_W * GRID_H - 1);
    localparam logic [7:0]        RD_LIMIT  = 8'(RD_LAT);
    localparam logic [7:0]        TO_LIMIT  = 8'(TIMEOUT - 1);

    seq_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wait;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_we;
    logic              r_collValid;
    cell_t             r_collData;
    cell_t             r_wrData;

    // Sequencer FSM: address counter, shared read/collide wait counter and all registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wait      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_we        <= 1'b0;
            r_collValid <= 1'b0;
            r_collData  <= '0;
            r_wrData    <= '0;
        end else begin
            r_collValid <= 1'b0;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        r_err   <= 1'b0;
                        r_addr  <= '0;
                        r_wait  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (r_wait == RD_LIMIT) begin
                        r_collData  <= bram_rd_data_in;
                        r_collValid <= 1'b1;
                        r_wait      <= '0;
                        r_state     <= COLLIDE;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                COLLIDE: begin
                    if (coll_done_in) begin
                        r_wrData <= coll_data_in;
                        r_we     <= 1'b1;
                        r_state  <= WRITE;
                    end else if (r_wait == TO_LIMIT) begin
                        r_err    <= 1'b1;
                        r_wrData <= r_collData;
                        r_we     <= 1'b1;
                        r_state  <= WRITE;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                WRITE: begin
                    if (r_addr == LAST_ADDR) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FINISH;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_wait  <= '0;
                        r_state <= RD_WAIT;
                    end
                end
                FINISH: begin
                    r_addr  <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_out         = r_busy;
    assign done_out         = r_done;
    assign err_out          = r_err;
    assign bram_addr_out    = r_addr;
    assign bram_we_out      = r_we;
    assign bram_wr_data_out = r_wrData;
    assign coll_data_out    = r_collData;
    assign coll_valid_out   = r_collValid;

endmodule

// File: tb/tb_collision_sequencer.sv
// Bench for collision_sequencer on a 4x2 lattice: a BRAM read model with two cycles of latency,
// a collision stub answering lane+1 after a configurable latency, and a write scoreboard.
module tb_collision_sequencer;
    import lbm_pkg::*;

    localparam int GW    = 4;
    localparam int GH    = 2;
    localparam int AW    = 3;
    localparam int RDL   = 2;
    localparam int TO    = 63;
    localparam int CELLS = GW * GH;

    typedef struct packed {
        logic [AW-1:0] addr;
        cell_t         data;
    } wr_t;

    logic          clk_in;
    logic          rst_in;
    logic          start_in;
    logic          busyOut;
    logic          doneOut;
    logic          errOut;
    logic [AW-1:0] bramAddr;
    cell_t         bramRdData;
    logic          bramWe;
    cell_t         bramWrData;
    cell_t         collData;
    logic          collValid;
    cell_t         collDataIn;
    logic          collDoneIn;

    int    seed;
    cell_t pipe0;
    cell_t pipe1;

    int    stubLat;
    int    stubSilent;
    logic  stubDone;
    logic  stubBusy;
    int    stubCnt;
    cell_t stubResp;
    logic  spurDone;

    wr_t   expQ[$];
    wr_t   popped;
    int    totalChecks;
    int    passChecks;
    int    sbTotal;
    int    sbPass;
    int    doneCount;
    int    validCount;
    int    validErr;
    int    stableErr;
    logic  prevValid;
    logic  holding;
    cell_t heldData;

    collision_sequencer #(
        .GRID_W (GW),
        .GRID_H (GH),
        .ADDR_W (AW),
        .RD_LAT (RDL),
        .TIMEOUT(TO)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .busy_out        (busyOut),
        .done_out        (doneOut),
        .err_out         (errOut),
        .bram_addr_out   (bramAddr),
        .bram_rd_data_in (bramRdData),
        .bram_we_out     (bramWe),
        .bram_wr_data_out(bramWrData),
        .coll_data_out   (collData),
        .coll_valid_out  (collValid),
        .coll_data_in    (collDataIn),
        .coll_done_in    (collDoneIn)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Lattice contents as a function of a per-pass seed; lane values include 8'hFF to exercise wrap.
    function automatic cell_t cellFor(input int s, input int a);
        cell_t c;
        for (int l = 0; l < Q; l++) c[l] = 8'((255 + s * 37 + a * 9 + l * 29) & 255);
        return c;
    endfunction

    function automatic cell_t plusOne(input cell_t c);
        cell_t r;
        for (int l = 0; l < Q; l++) r[l] = c[l] + 8'd1;
        return r;
    endfunction

    // BRAM read model: data for the address presented in cycle t is on the bus in cycle t+2.
    always @(posedge clk_in) begin
        pipe0 <= cellFor(seed, int'(bramAddr));
        pipe1 <= pipe0;
    end
    assign bramRdData = pipe1;

    // Collision stub: done arrives in the (stubLat)th cycle counting the valid cycle as the first.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stubDone <= 1'b0;
            stubBusy <= 1'b0;
            stubCnt  <= 0;
            stubResp <= '0;
        end else begin
            stubDone <= 1'b0;
            if (collValid) begin
                stubResp <= plusOne(collData);
                stubCnt  <= 1;
                stubBusy <= (int'(bramAddr) != stubSilent);
            end else if (stubBusy) begin
                if (stubCnt == stubLat - 2) begin
                    stubDone <= 1'b1;
                    stubBusy <= 1'b0;
                end
                stubCnt <= stubCnt + 1;
            end
        end
    end
    assign collDataIn = stubResp;
    assign collDoneIn = stubDone | spurDone;

    // Scoreboard and handshake monitor, sampled on the falling edge.
    initial begin
        sbTotal = 0; sbPass = 0; prevValid = 1'b0; holding = 1'b0; heldData = '0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                prevValid = 1'b0;
                holding   = 1'b0;
            end else begin
                if (bramWe) begin
                    sbTotal++;
                    if (expQ.size() == 0) begin
                        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write", bramAddr, bramWrData);
                    end else begin
                        popped = expQ.pop_front();
                        if (bramAddr !== popped.addr || bramWrData !== popped.data)
                            $display("[TB] FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                                     bramAddr, bramWrData, popped.addr, popped.data);
                        else
                            sbPass++;
                    end
                end
                if (doneOut) doneCount++;
                if (collValid) begin
                    validCount++;
                    if (prevValid) validErr++;
                    heldData = collData;
                    holding  = 1'b1;
                end else if (holding && collData !== heldData) begin
                    stableErr++;
                end
                if (bramWe) holding = 1'b0;
                prevValid = collValid;
            end
        end
    end

    task automatic pushExpected(input int s, input int silent);
        wr_t e;
        for (int a = 0; a < CELLS; a++) begin
            e.addr = AW'(a);
            e.data = (a == silent) ? cellFor(s, a) : plusOne(cellFor(s, a));
            expQ.push_back(e);
        end
    endtask

    // Leaves the caller at the falling edge of the first RD_WAIT cycle (pass cycle 0).
    task automatic startPass();
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
    endtask

    // cycles = 1 at the current falling edge; returns at the edge where done_out is high.
    task automatic waitForDone(input int budget, output int cycles, output bit seen);
        int n;
        n = 1;
        while (!doneOut && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        cycles = n;
        seen   = doneOut;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; start_in = 1'b0; spurDone = 1'b0;
        seed = 0; stubLat = 18; stubSilent = -1;
        repeat (3) @(negedge clk_in);
        totalChecks++; if (busyOut !== 1'b0) $display("[TB] FAIL rst_busy: got %b required 0", busyOut); else passChecks++;
        totalChecks++; if (doneOut !== 1'b0) $display("[TB] FAIL rst_done: got %b required 0", doneOut); else passChecks++;
        totalChecks++; if (errOut !== 1'b0) $display("[TB] FAIL rst_err: got %b required 0", errOut); else passChecks++;
        totalChecks++; if (bramAddr !== '0) $display("[TB] FAIL rst_addr: got %0d required 0", bramAddr); else passChecks++;
        totalChecks++; if (bramWe !== 1'b0) $display("[TB] FAIL rst_we: got %b required 0", bramWe); else passChecks++;
        totalChecks++; if (collValid !== 1'b0) $display("[TB] FAIL rst_valid: got %b required 0", collValid); else passChecks++;
        totalChecks++; if (bramWrData !== '0) $display("[TB] FAIL rst_wrdata: got %h required 0", bramWrData); else passChecks++;
        totalChecks++; if (collData !== '0) $display("[TB] FAIL rst_colldata: got %h required 0", collData); else passChecks++;
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        totalChecks++; if (busyOut !== 1'b0) $display("[TB] FAIL idle_busy: got %b required 0", busyOut); else passChecks++;
    endtask

    task automatic test_full_pass();
        int  cyc;
        bit  seen;
        int  wrBefore;
        seed = 0; stubSilent = -1; doneCount = 0; validCount = 0; validErr = 0; stableErr = 0;
        wrBefore = sbTotal;
        pushExpected(seed, -1);
        startPass();
        totalChecks++; if (busyOut !== 1'b1) $display("[TB] FAIL full_busy_start: got %b required 1", busyOut); else passChecks++;
        waitForDone(400, cyc, seen);
        totalChecks++; if (seen !== 1'b1) $display("[TB] FAIL full_done_seen: got %b required 1", seen); else passChecks++;
        totalChecks++; if (cyc != CELLS * (RDL + 1 + 18 + 1) + 1) $display("[TB] FAIL full_cycles: got %0d required %0d", cyc, CELLS * (RDL + 1 + 18 + 1) + 1); else passChecks++;
        totalChecks++; if (busyOut !== 1'b0) $display("[TB] FAIL full_busy_drop: got %b required 0", busyOut); else passChecks++;
        repeat (3) @(negedge clk_in);
        totalChecks++; if (doneCount != 1) $display("[TB] FAIL full_done_count: got %0d required 1", doneCount); else passChecks++;
        totalChecks++; if (sbTotal - wrBefore != CELLS) $display("[TB] FAIL full_write_count: got %0d required %0d", sbTotal - wrBefore, CELLS); else passChecks++;
        totalChecks++; if (expQ.size() != 0) $display("[TB] FAIL full_pending: got %0d required 0", expQ.size()); else passChecks++;
        totalChecks++; if (errOut !== 1'b0) $display("[TB] FAIL full_err: got %b required 0", errOut); else passChecks++;
        totalChecks++; if (bramAddr !== '0) $display("[TB] FAIL full_idle_addr: got %0d required 0", bramAddr); else passChecks++;
        totalChecks++; if (validCount != CELLS) $display("[TB] FAIL valid_count: got %0d required %0d", validCount, CELLS); else passChecks++;
        totalChecks++; if (validErr != 0) $display("[TB] FAIL valid_width: got %0d long pulses required 0", validErr); else passChecks++;
        totalChecks++; if (stableErr != 0) $display("[TB] FAIL colldata_stable: got %0d changes required 0", stableErr); else passChecks++;
    endtask

    task automatic test_timeout();
        int cyc;
        bit seen;
        seed = 5; stubSilent = 3; doneCount = 0;
        pushExpected(seed, 3);
        startPass();
        repeat (59) @(negedge clk_in);
        totalChecks++; if (errOut !== 1'b0) $display("[TB] FAIL to_err_early: got %b required 0", errOut); else passChecks++;
        waitForDone(1000, cyc, seen);
        totalChecks++; if (seen !== 1'b1) $display("[TB] FAIL to_done_seen: got %b required 1", seen); else passChecks++;
        totalChecks++; if (59 + cyc - 1 != 7 * 22 + (RDL + 1 + TO + 1))
            $display("[TB] FAIL to_done_cycle: got %0d required %0d", 59 + cyc - 1, 7 * 22 + (RDL + 1 + TO + 1)); else passChecks++;
        repeat (3) @(negedge clk_in);
        totalChecks++; if (errOut !== 1'b1) $display("[TB] FAIL to_err_sticky: got %b required 1", errOut); else passChecks++;
        totalChecks++; if (doneCount != 1) $display("[TB] FAIL to_done_count: got %0d required 1", doneCount); else passChecks++;
        totalChecks++; if (expQ.size() != 0) $display("[TB] FAIL to_pending: got %0d required 0", expQ.size()); else passChecks++;
        stubSilent = -1;
    endtask

    task automatic test_start_ignored();
        int cyc;
        bit seen;
        int wrBefore;
        seed = 9; doneCount = 0;
        wrBefore = sbTotal;
        pushExpected(seed, -1);
        startPass();
        repeat (5) @(negedge clk_in);
        totalChecks++; if (errOut !== 1'b0) $display("[TB] FAIL si_err_cleared: got %b required 0", errOut); else passChecks++;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        totalChecks++; if (busyOut !== 1'b1) $display("[TB] FAIL si_busy: got %b required 1", busyOut); else passChecks++;
        repeat (34) @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        waitForDone(400, cyc, seen);
        totalChecks++; if (seen !== 1'b1) $display("[TB] FAIL si_done_seen: got %b required 1", seen); else passChecks++;
        totalChecks++; if (41 + cyc - 1 != 176) $display("[TB] FAIL si_done_cycle: got %0d required 176", 41 + cyc - 1); else passChecks++;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        totalChecks++; if (busyOut !== 1'b0) $display("[TB] FAIL si_finish_start: got busy %b required 0", busyOut); else passChecks++;
        repeat (30) @(negedge clk_in);
        totalChecks++; if (doneCount != 1) $display("[TB] FAIL si_done_count: got %0d required 1", doneCount); else passChecks++;
        totalChecks++; if (sbTotal - wrBefore != CELLS) $display("[TB] FAIL si_write_count: got %0d required %0d", sbTotal - wrBefore, CELLS); else passChecks++;
    endtask

    task automatic test_spurious_done();
        int cyc;
        bit seen;
        seed = 13; doneCount = 0;
        pushExpected(seed, -1);
        startPass();
        spurDone = 1'b1;
        @(negedge clk_in);
        spurDone = 1'b0;
        totalChecks++; if (bramWe !== 1'b0) $display("[TB] FAIL sp_no_write: got %b required 0", bramWe); else passChecks++;
        totalChecks++; if (collValid !== 1'b0) $display("[TB] FAIL sp_no_valid: got %b required 0", collValid); else passChecks++;
        repeat (2) @(negedge clk_in);
        totalChecks++; if (collValid !== 1'b1) $display("[TB] FAIL sp_valid_time: got %b required 1", collValid); else passChecks++;
        waitForDone(400, cyc, seen);
        totalChecks++; if (3 + cyc - 1 != 176) $display("[TB] FAIL sp_done_cycle: got %0d required 176", 3 + cyc - 1); else passChecks++;
        repeat (2) @(negedge clk_in);
        totalChecks++; if (expQ.size() != 0) $display("[TB] FAIL sp_pending: got %0d required 0", expQ.size()); else passChecks++;
    endtask

    task automatic test_reset_midpass();
        int cyc;
        bit seen;
        seed = 21; doneCount = 0;
        pushExpected(seed, -1);
        startPass();
        repeat (50) @(negedge clk_in);
        totalChecks++; if (bramAddr !== AW'(2)) $display("[TB] FAIL rm_addr: got %0d required 2", bramAddr); else passChecks++;
        #2 rst_in = 1'b1;
        #1;
        totalChecks++; if (busyOut !== 1'b0) $display("[TB] FAIL rm_busy: got %b required 0", busyOut); else passChecks++;
        totalChecks++; if (bramWe !== 1'b0) $display("[TB] FAIL rm_we: got %b required 0", bramWe); else passChecks++;
        totalChecks++; if (bramAddr !== '0) $display("[TB] FAIL rm_addr0: got %0d required 0", bramAddr); else passChecks++;
        totalChecks++; if (errOut !== 1'b0) $display("[TB] FAIL rm_err: got %b required 0", errOut); else passChecks++;
        totalChecks++; if (collData !== '0) $display("[TB] FAIL rm_colldata: got %h required 0", collData); else passChecks++;
        @(negedge clk_in);
        rst_in = 1'b0;
        expQ.delete();
        @(negedge clk_in);
        totalChecks++; if (doneCount != 0) $display("[TB] FAIL rm_no_done: got %0d required 0", doneCount); else passChecks++;
        seed = 22;
        pushExpected(seed, -1);
        startPass();
        totalChecks++; if (bramAddr !== '0) $display("[TB] FAIL rm_restart_addr: got %0d required 0", bramAddr); else passChecks++;
        waitForDone(400, cyc, seen);
        totalChecks++; if (cyc != 177) $display("[TB] FAIL rm_cycles: got %0d required 177", cyc); else passChecks++;
        repeat (2) @(negedge clk_in);
        totalChecks++; if (expQ.size() != 0) $display("[TB] FAIL rm_pending: got %0d required 0", expQ.size()); else passChecks++;
        totalChecks++; if (doneCount != 1) $display("[TB] FAIL rm_done_count: got %0d required 1", doneCount); else passChecks++;
    endtask

    initial begin
        totalChecks = 0; passChecks = 0; doneCount = 0;
        validCount = 0; validErr = 0; stableErr = 0;
        test_reset();
        test_full_pass();
        test_timeout();
        test_start_ignored();
        test_spurious_done();
        test_reset_midpass();
        repeat (2) @(negedge clk_in);
        passChecks  = passChecks + sbPass;
        totalChecks = totalChecks + sbTotal;
        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule
